// File: rtl/ro_meas_ctrl.sv
// Ring-oscillator measurement sequencer: enables one oscillator, flushes its synchroniser,
// then counts its rising edges over a programmable clk-cycle gate window.
module ro_meas_ctrl #(
    parameter int NUM_RO     = 4,
    parameter int SEL_W      = 2,
    parameter int GATE_W     = 16,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [SEL_W-1:0]  sel,
    input  logic [GATE_W-1:0] gate_cycles,
    input  logic [NUM_RO-1:0] ro_in,
    output logic [NUM_RO-1:0] ro_en,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);

    localparam int SET_W = $clog2(SETTLE_CYC + 1);
    localparam logic [SET_W-1:0]  SETTLE_LD  = SET_W'(SETTLE_CYC);
    localparam logic [SET_W-1:0]  SETTLE_ONE = SET_W'(1);
    localparam logic [GATE_W-1:0] GATE_ONE   = GATE_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t             state_r, state_nx;
    logic [SEL_W-1:0]   sel_r, sel_nx;
    logic [SET_W-1:0]   settle_cnt_r, settle_cnt_nx;
    logic [GATE_W-1:0]  gate_cnt_r, gate_cnt_nx;
    logic [CNT_W-1:0]   edge_cnt_r, edge_cnt_nx;
    logic               sat_r, sat_nx;
    logic               sync1_r, sync2_r, hist_r;
    logic               edge_s;
    logic [NUM_RO-1:0]  ro_en_r, ro_en_nx;
    logic               busy_r, busy_nx;
    logic               done_r, done_nx;
    logic [CNT_W-1:0]   count_r, count_nx;
    logic               ovf_r, ovf_nx;

    assign edge_s = sync2_r & ~hist_r;

    // Next-state, counter and registered-output decode
    always_comb begin
        state_nx      = state_r;
        sel_nx        = sel_r;
        settle_cnt_nx = settle_cnt_r;
        gate_cnt_nx   = gate_cnt_r;
        edge_cnt_nx   = edge_cnt_r;
        sat_nx        = sat_r;
        count_nx      = count_r;
        ovf_nx        = ovf_r;
        ro_en_nx      = '0;
        case (state_r)
            ST_IDLE: begin
                if (start && !abort) begin
                    sel_nx        = sel;
                    settle_cnt_nx = SETTLE_LD;
                    if (gate_cycles == '0) begin
                        gate_cnt_nx = GATE_ONE;
                    end else begin
                        gate_cnt_nx = gate_cycles;
                    end
                    state_nx = ST_SETTLE;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else if (settle_cnt_r == SETTLE_ONE) begin
                    edge_cnt_nx = '0;
                    sat_nx      = 1'b0;
                    state_nx    = ST_MEASURE;
                end else begin
                    settle_cnt_nx = settle_cnt_r - SETTLE_ONE;
                end
            end
            ST_MEASURE: begin
                if (abort) begin
                    state_nx = ST_IDLE;
                end else begin
                    if (edge_s) begin
                        if (edge_cnt_r == CNT_MAX) begin
                            sat_nx = 1'b1;
                        end else begin
                            edge_cnt_nx = edge_cnt_r + CNT_ONE;
                        end
                    end else begin
                        edge_cnt_nx = edge_cnt_r;
                    end
                    // Result is captured together with the last window increment
                    if (gate_cnt_r == GATE_ONE) begin
                        count_nx = edge_cnt_nx;
                        ovf_nx   = sat_nx;
                        state_nx = ST_DONE;
                    end else begin
                        gate_cnt_nx = gate_cnt_r - GATE_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
        busy_nx = (state_nx != ST_IDLE);
        done_nx = (state_nx == ST_DONE);
        if ((state_nx == ST_SETTLE) || (state_nx == ST_MEASURE)) begin
            ro_en_nx[sel_nx] = 1'b1;
        end else begin
            ro_en_nx = '0;
        end
    end

    // FSM state and measurement datapath registers
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_r      <= ST_IDLE;
            sel_r        <= '0;
            settle_cnt_r <= '0;
            gate_cnt_r   <= '0;
            edge_cnt_r   <= '0;
            sat_r        <= 1'b0;
        end else begin
            state_r      <= state_nx;
            sel_r        <= sel_nx;
            settle_cnt_r <= settle_cnt_nx;
            gate_cnt_r   <= gate_cnt_nx;
            edge_cnt_r   <= edge_cnt_nx;
            sat_r        <= sat_nx;
        end
    end

    // Selected oscillator synchroniser plus history flop for edge detection
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            hist_r  <= 1'b0;
        end else begin
            sync1_r <= ro_in[sel_r];
            sync2_r <= sync1_r;
            hist_r  <= sync2_r;
        end
    end

    // Registered outputs
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ro_en_r <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            ro_en_r <= ro_en_nx;
            busy_r  <= busy_nx;
            done_r  <= done_nx;
            count_r <= count_nx;
            ovf_r   <= ovf_nx;
        end
    end

    assign ro_en = ro_en_r;
    assign busy  = busy_r;
    assign done  = done_r;
    assign count = count_r;
    assign ovf   = ovf_r;

endmodule

// File: doc/ro_meas_ctrl.md
# ro_meas_ctrl

Measurement sequencer for the ring-oscillator bank. It enables exactly one of NUM_RO free-running oscillators and synchronises that oscillator's output into the `clk` domain. It then counts the oscillator's rising edges over a programmable gate window of `clk` cycles and reports the count with a done pulse. It sits between the top-level I/O wrapper, which supplies start, select and gate length, and the oscillator instances, which it gates through per-oscillator enables so that only one oscillator runs at a time.

## Interface
- NUM_RO, 4: number of oscillators managed. Must be ≥ 2.
- SEL_W, 2: select width, equal to clog2(NUM_RO).
- GATE_W, 16: gate-length width, in `clk` cycles.
- CNT_W, 16: result counter width.
- SETTLE_CYC, 4: cycles the selected oscillator runs before counting starts. Covers the synchroniser flush. Must be ≥ 3.

- clk  in  1  system clock; the only clock.
- rst_n  in  1  asynchronous, active-high reset. Asserted = 1, despite the name.
- start  in  1  request a measurement; sampled only in IDLE.
- abort  in  1  cancel the current measurement; return to IDLE with no done pulse.
- sel  in  SEL_W  oscillator index; latched when start is accepted.
- gate_cycles  in  GATE_W  gate length; latched when start is accepted. A value of 0 is treated as 1.
- ro_in  in  NUM_RO  raw oscillator outputs; asynchronous to `clk`.
- ro_en  out  NUM_RO  oscillator enables; one-hot or all zero.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a result is valid.
- count  out  CNT_W  edge count of the last completed measurement.
- ovf  out  1  the last measurement saturated `count`.

## Operation
- Reset value of all outputs is 0: `ro_en`, `busy`, `done`, `count`, `ovf`. The FSM resets to IDLE, and all internal counters and synchroniser flops reset to 0.
- The FSM has four states:
  - IDLE. `ro_en` = 0 and `busy` = 0. If `start` = 1 and `abort` = 0:
    - latch `sel` and max(`gate_cycles`, 1);
    - load the settle counter with SETTLE_CYC;
    - go to SETTLE.
  - SETTLE. `ro_en[sel_l]` = 1. The settle counter decrements each cycle. When it reaches 1:
    - clear the edge counter;
    - load the gate counter;
    - go to MEASURE.
  - MEASURE. `ro_en[sel_l]` = 1. The gate counter decrements each cycle. Each cycle with an edge pulse increments the edge counter, which saturates at 2^CNT_W−1. When the gate counter reaches 1, go to DONE.
  - DONE. Lasts one cycle:
    - `done` = 1;
    - `count` and `ovf` take the edge-counter result;
    - `ro_en` = 0;
    - go to IDLE.
- Edge detection:
  - `ro_in[sel_l]` passes through a 2-flop synchroniser followed by a history flop.
  - edge pulse = sync2 & ~hist.
  - The mux comes before the synchroniser, so a stale value from a previously selected oscillator is flushed during SETTLE.
- `ovf` = 1 if any increment was attempted while the edge counter was at its maximum. In that case `count` reads all ones.
- `count` and `ovf` hold their values until the next DONE. Neither abort nor IDLE clears them.
- `abort` = 1 in SETTLE or MEASURE forces IDLE on the next edge: `ro_en` = 0, `busy` = 0, no done pulse, `count` and `ovf` unchanged. `abort` has priority over `start` in IDLE.
- `start` while `busy` = 1 is ignored and has no queueing effect. `sel` and `gate_cycles` may change freely after acceptance.
- Asynchronous reset at any time, including mid-MEASURE, immediately drives all outputs to their reset values. No done pulse results.
- Gate counter arithmetic is GATE_W bits. A gate of 2^GATE_W−1 is legal and does not wrap.

## Timing
- Start is accepted on clock edge E0. `busy` and `ro_en` rise after E0.
- SETTLE occupies SETTLE_CYC cycles and MEASURE occupies G cycles, where G = max(`gate_cycles`, 1).
- `done` is high for exactly one cycle, following edge E0 + SETTLE_CYC + G. `busy` falls after the next edge, which means `busy` is still 1 while `done` = 1.
- The earliest next start is the cycle in which `busy` = 0. Back-to-back measurements therefore have SETTLE_CYC + G + 2 cycles per result.
- The counting window is the G MEASURE cycles. Edge pulses lag the oscillator by 2–3 cycles, so the measured count has ±1 tolerance.
- The oscillator frequency must be below f_clk/2 for a correct count. Faster oscillators alias, and this is not detected.

## Test plan
- Basic measurement. Model `ro_in[1]` toggling every 5 `clk` cycles; `sel` = 1, `gate_cycles` = 100. Required: `done` follows edge E0+104; `count` ∈ {9, 10, 11}; `ovf` = 0; `ro_en` = 4'b0010 only while `busy` = 1.
- Isolation. Drive all oscillators with different rates, for example period 4/10/20/40 on `ro_in[0..3]`, and run `sel` = 0..3 with gate 200. Required counts ≈ 50/20/10/5, each ±1, and `ro_en` is always one-hot.
- Saturation. Set CNT_W = 4, `ro_in[0]` period 4, gate 200. Required: `count` = 15 and `ovf` = 1. A following measurement that does not saturate clears `ovf` to 0.
- Gate zero and ignored start. With `gate_cycles` = 0, `done` follows edge E0 + SETTLE_CYC + 1. A `start` pulse while `busy` = 1 causes no extra done and no state change.
- Abort. Assert `abort` for 1 cycle in the 50th MEASURE cycle. Required: `busy` and `ro_en` = 0 after the next edge; no `done`; `count` retains its prior value. Then start again and complete normally.
- Reset mid-operation. Assert `rst_n` = 1 asynchronously between clock edges during MEASURE. Required: `ro_en`, `busy`, `done`, `count` and `ovf` go to 0 without waiting for a clock edge. After release, the FSM is in IDLE and the next start gives a correct count.
